// File: rtl/timer_set_seq.sv
// Multi-field value editor: set/inc/dec/cancel buttons walk and adjust
// bounded fields, then commit them or abort on cancel or idle timeout.
`timescale 1ns/1ps
module timer_set_seq #(
  parameter  int NUM_FIELDS = 3,
  parameter  int FIELD_W    = 6,
  parameter  int TIMEOUT    = 1000,
  localparam int SEL_W = (NUM_FIELDS > 2) ? $clog2(NUM_FIELDS) : 1,
  localparam int TO_W  = $clog2(TIMEOUT + 1),
  localparam int VW    = NUM_FIELDS * FIELD_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               set_btn,
  input  logic               inc_btn,
  input  logic               dec_btn,
  input  logic               cancel_btn,
  input  logic [VW-1:0]      cur_val,
  input  logic [VW-1:0]      field_min,
  input  logic [VW-1:0]      field_max,
  output logic               editing,
  output logic [SEL_W-1:0]   sel,
  output logic [FIELD_W-1:0] edit_val,
  output logic               commit,
  output logic [VW-1:0]      commit_val,
  output logic               timed_out
);

  typedef enum logic [1:0] {
    IDLE, LOAD, EDIT, COMMIT
  } state_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_FIELDS - 1);

  state_t             state, state_d;
  logic [VW-1:0]      fld, fld_d;
  logic [SEL_W-1:0]   sel_d;
  logic [TO_W-1:0]    to_cnt, to_d;
  logic [FIELD_W-1:0] cur_f, mn_f, mx_f;
  logic [FIELD_W-1:0] inc_v, dec_v, nv;
  logic               any_btn, expire;

  assign any_btn = set_btn | inc_btn | dec_btn | cancel_btn;
  assign expire  = (to_cnt == TO_W'(TIMEOUT - 1)) && !any_btn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:   if (set_btn) state_d = LOAD;
      LOAD:   state_d = EDIT;
      EDIT: begin
        if (cancel_btn)                   state_d = IDLE;
        else if (set_btn && sel == LAST) state_d = COMMIT;
        else if (expire)                  state_d = IDLE;
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_f = '0;
    mn_f  = '0;
    mx_f  = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (sel == SEL_W'(i)) begin
        cur_f = fld[i*FIELD_W +: FIELD_W];
        mn_f  = field_min[i*FIELD_W +: FIELD_W];
        mx_f  = field_max[i*FIELD_W +: FIELD_W];
      end
    end
    inc_v = (cur_f == mx_f) ? mn_f : cur_f + 1'b1;
    dec_v = (cur_f == mn_f) ? mx_f : cur_f - 1'b1;
  end

  always_comb begin
    fld_d = fld;
    sel_d = sel;
    to_d  = to_cnt;
    unique case (state)
      LOAD: begin
        for (int i = 0; i < NUM_FIELDS; i++) begin
          if (cur_val[i*FIELD_W +: FIELD_W] >= field_min[i*FIELD_W +: FIELD_W] &&
              cur_val[i*FIELD_W +: FIELD_W] <= field_max[i*FIELD_W +: FIELD_W])
            fld_d[i*FIELD_W +: FIELD_W] = cur_val[i*FIELD_W +: FIELD_W];
          else
            fld_d[i*FIELD_W +: FIELD_W] = field_min[i*FIELD_W +: FIELD_W];
        end
        sel_d = '0;
        to_d  = '0;
      end
      EDIT: begin
        to_d = (any_btn || expire) ? '0 : to_cnt + 1'b1;
        if (cancel_btn || expire) begin
          sel_d = '0;
        end else if (set_btn) begin
          if (sel != LAST) sel_d = sel + 1'b1;
        end else if (inc_btn != dec_btn) begin
          for (int i = 0; i < NUM_FIELDS; i++)
            if (sel == SEL_W'(i))
              fld_d[i*FIELD_W +: FIELD_W] = inc_btn ? inc_v : dec_v;
        end
      end
      COMMIT: sel_d = '0;
      default: ;
    endcase
    nv = '0;
    for (int i = 0; i < NUM_FIELDS; i++)
      if (sel_d == SEL_W'(i)) nv = fld_d[i*FIELD_W +: FIELD_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fld        <= '0;
      sel        <= '0;
      to_cnt     <= '0;
      editing    <= 1'b0;
      edit_val   <= '0;
      commit     <= 1'b0;
      commit_val <= '0;
      timed_out  <= 1'b0;
    end else begin
      fld       <= fld_d;
      sel       <= sel_d;
      to_cnt    <= to_d;
      editing   <= (state_d != IDLE);
      edit_val  <= nv;
      commit    <= (state_d == COMMIT);
      timed_out <= (state == EDIT) && expire;
      if (state_d == COMMIT) commit_val <= fld_d;
    end
  end

endmodule

// File: tb/tb_timer_set_seq.sv
// Bench for timer_set_seq: vector table for edit flows plus
// hand-written timeout and mid-edit reset sequences.
`timescale 1ns/1ps
module tb_timer_set_seq;

  typedef struct {
    logic [3:0]  btn;
    logic [17:0] cur;
    logic        editing;
    logic [1:0]  sel;
    logic [5:0]  val;
    logic        commit;
  } vec_t;

  localparam logic [3:0] S = 4'b1000;
  localparam logic [3:0] I = 4'b0100;
  localparam logic [3:0] D = 4'b0010;
  localparam logic [3:0] C = 4'b0001;
  localparam logic [3:0] N = 4'b0000;

  localparam logic [17:0] CA = {6'd45, 6'd30, 6'd12};
  localparam logic [17:0] CB = {6'd45, 6'd0, 6'd23};
  localparam logic [17:0] CX = {6'd1, 6'd1, 6'd1};
  localparam logic [17:0] CC = {6'd45, 6'd63, 6'd12};
  localparam logic [17:0] CV = {6'd45, 6'd29, 6'd14};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        set_btn, inc_btn, dec_btn, cancel_btn;
  logic [17:0] cur_val, field_min, field_max;

  logic        editing, commit, timed_out;
  logic [1:0]  sel;
  logic [5:0]  edit_val;
  logic [17:0] commit_val;

  logic        t_editing, t_commit, t_timed_out;
  logic [1:0]  t_sel;
  logic [5:0]  t_edit_val;
  logic [17:0] t_commit_val;

  int checks = 0;
  int errors = 0;
  int n_commit = 0, n_to = 0, t_n_commit = 0, t_n_to = 0;

  vec_t tv [23];

  timer_set_seq dut (
    .clk(clk), .rst_n(rst_n),
    .set_btn(set_btn), .inc_btn(inc_btn),
    .dec_btn(dec_btn), .cancel_btn(cancel_btn),
    .cur_val(cur_val), .field_min(field_min),
    .field_max(field_max),
    .editing(editing), .sel(sel), .edit_val(edit_val),
    .commit(commit), .commit_val(commit_val),
    .timed_out(timed_out)
  );

  timer_set_seq #(.TIMEOUT(10)) dut_t (
    .clk(clk), .rst_n(rst_n),
    .set_btn(set_btn), .inc_btn(inc_btn),
    .dec_btn(dec_btn), .cancel_btn(cancel_btn),
    .cur_val(cur_val), .field_min(field_min),
    .field_max(field_max),
    .editing(t_editing), .sel(t_sel), .edit_val(t_edit_val),
    .commit(t_commit), .commit_val(t_commit_val),
    .timed_out(t_timed_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (commit)      n_commit++;
    if (timed_out)   n_to++;
    if (t_commit)    t_n_commit++;
    if (t_timed_out) t_n_to++;
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] b);
    @(negedge clk);
    {set_btn, inc_btn, dec_btn, cancel_btn} = b;
    @(posedge clk);
    #1;
    {set_btn, inc_btn, dec_btn, cancel_btn} = 4'b0;
  endtask

  function automatic vec_t mk(input logic [3:0] b,
                              input logic [17:0] c,
                              input logic e,
                              input logic [1:0] s,
                              input logic [5:0] v,
                              input logic cm);
    vec_t r;
    r.btn = b; r.cur = c; r.editing = e;
    r.sel = s; r.val = v; r.commit = cm;
    return r;
  endfunction

  initial begin
    int hit;
    int t_commit_before;

    tv[0]  = mk(S,     CA, 1'b1, 2'd0, 6'd0,  1'b0);
    tv[1]  = mk(N,     CA, 1'b1, 2'd0, 6'd12, 1'b0);
    tv[2]  = mk(I,     CA, 1'b1, 2'd0, 6'd13, 1'b0);
    tv[3]  = mk(I,     CA, 1'b1, 2'd0, 6'd14, 1'b0);
    tv[4]  = mk(S,     CA, 1'b1, 2'd1, 6'd30, 1'b0);
    tv[5]  = mk(D,     CA, 1'b1, 2'd1, 6'd29, 1'b0);
    tv[6]  = mk(S,     CA, 1'b1, 2'd2, 6'd45, 1'b0);
    tv[7]  = mk(S,     CA, 1'b1, 2'd2, 6'd45, 1'b1);
    tv[8]  = mk(S,     CA, 1'b0, 2'd0, 6'd14, 1'b0);
    tv[9]  = mk(S,     CB, 1'b1, 2'd0, 6'd14, 1'b0);
    tv[10] = mk(I,     CB, 1'b1, 2'd0, 6'd23, 1'b0);
    tv[11] = mk(I,     CB, 1'b1, 2'd0, 6'd0,  1'b0);
    tv[12] = mk(S,     CB, 1'b1, 2'd1, 6'd0,  1'b0);
    tv[13] = mk(D,     CB, 1'b1, 2'd1, 6'd59, 1'b0);
    tv[14] = mk(I | D, CX, 1'b1, 2'd1, 6'd59, 1'b0);
    tv[15] = mk(S,     CX, 1'b1, 2'd2, 6'd45, 1'b0);
    tv[16] = mk(S | C, CX, 1'b0, 2'd0, 6'd0,  1'b0);
    tv[17] = mk(N,     CX, 1'b0, 2'd0, 6'd0,  1'b0);
    tv[18] = mk(S,     CC, 1'b1, 2'd0, 6'd0,  1'b0);
    tv[19] = mk(N,     CC, 1'b1, 2'd0, 6'd12, 1'b0);
    tv[20] = mk(S,     CC, 1'b1, 2'd1, 6'd0,  1'b0);
    tv[21] = mk(C,     CC, 1'b0, 2'd0, 6'd12, 1'b0);
    tv[22] = mk(I,     CC, 1'b0, 2'd0, 6'd12, 1'b0);

    rst_n = 1'b0;
    {set_btn, inc_btn, dec_btn, cancel_btn} = 4'b0;
    cur_val   = CA;
    field_min = '0;
    field_max = {6'd59, 6'd59, 6'd23};
    #12;
    chk("rst_editing",    editing, 1'b0);
    chk("rst_sel",        sel, 2'd0);
    chk("rst_edit_val",   edit_val, 6'd0);
    chk("rst_commit",     commit, 1'b0);
    chk("rst_commit_val", commit_val, 18'd0);
    chk("rst_timed_out",  timed_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 23; k++) begin
      cur_val = tv[k].cur;
      cyc(tv[k].btn);
      chk($sformatf("v%0d_editing", k), editing, tv[k].editing);
      chk($sformatf("v%0d_sel", k), sel, tv[k].sel);
      chk($sformatf("v%0d_edit_val", k), edit_val, tv[k].val);
      chk($sformatf("v%0d_commit", k), commit, tv[k].commit);
      if (k == 7) chk("commit_val", commit_val, CV);
    end
    chk("commit_val_held", commit_val, CV);

    t_commit_before = t_n_commit;
    hit = 0;
    cyc(S);
    for (int k = 1; k <= 30; k++) begin
      cyc(N);
      if (t_timed_out && hit == 0) hit = k;
    end
    chk("to_cycle",    hit, 11);
    chk("to_editing",  t_editing, 1'b0);
    chk("to_no_commit", t_n_commit, t_commit_before);
    chk("to_pulses",   t_n_to, 1);
    chk("long_to_still_editing", editing, 1'b1);
    cyc(C);

    cur_val = {6'd3, 6'd2, 6'd1};
    cyc(S);
    cyc(N);
    cyc(I);
    cyc(S);
    cyc(S);
    chk("pre_rst_sel",     sel, 2'd2);
    chk("pre_rst_editing", editing, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_editing",  editing, 1'b0);
    chk("mid_rst_sel",      sel, 2'd0);
    chk("mid_rst_edit_val", edit_val, 6'd0);
    chk("mid_rst_t_sel",    t_sel, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) cyc(N);
    chk("post_rst_editing", editing, 1'b0);
    chk("post_rst_val",     edit_val, 6'd0);

    chk("commit_count",   n_commit, 1);
    chk("t_commit_count", t_n_commit, 1);
    chk("to_count",       n_to, 0);
    chk("t_to_count",     t_n_to, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_set_seq.md
TIMER_SET_SEQ -- requirements
Module: timer_set_seq

Interface
REQ-001 Parameter NUM_FIELDS, default 3, meaning number of editable fields (2..8).
REQ-002 Parameter FIELD_W, default 6, meaning width of each field value in bits.
REQ-003 Parameter TIMEOUT, default 1000, meaning idle cycles in edit mode before abort (>=2).
REQ-004 Local SEL_W = max(1, clog2(NUM_FIELDS)); TO_W = clog2(TIMEOUT+1).
REQ-005 clk  in  1  single clock; all state updates on posedge clk.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 set_btn  in  1  one-cycle pulse; enter set mode / advance field / confirm.
REQ-008 inc_btn  in  1  one-cycle pulse; increment selected field.
REQ-009 dec_btn  in  1  one-cycle pulse; decrement selected field.
REQ-010 cancel_btn  in  1  one-cycle pulse; abort edit without commit.
REQ-011 cur_val  in  NUM_FIELDS*FIELD_W  live field values; field i at [i*FIELD_W +: FIELD_W].
REQ-012 field_min  in  NUM_FIELDS*FIELD_W  per-field minimum, same packing; static while editing.
REQ-013 field_max  in  NUM_FIELDS*FIELD_W  per-field maximum, same packing; field_min <= field_max.
REQ-014 editing  out  1  high in LOAD, EDIT, COMMIT states.
REQ-015 sel  out  SEL_W  index of field being edited.
REQ-016 edit_val  out  FIELD_W  current value of selected field.
REQ-017 commit  out  1  one-cycle strobe when edited values are accepted.
REQ-018 commit_val  out  NUM_FIELDS*FIELD_W  edited values; valid while commit high, held afterwards.
REQ-019 timed_out  out  1  one-cycle strobe when edit aborted by timeout.

Function
REQ-020 FSM states IDLE, LOAD, EDIT, COMMIT; all outputs registered.
REQ-021 IDLE: set_btn -> LOAD; inc/dec/cancel ignored.
REQ-022 LOAD (1 cycle): each field register <= cur_val field if within [min,max], else field_min; sel <= 0; -> EDIT.
REQ-023 EDIT priority per cycle: cancel_btn > set_btn > inc_btn > dec_btn; inc_btn and dec_btn together without set/cancel -> no change.
REQ-024 EDIT inc: field[sel] == max -> min (wrap), else +1.
REQ-025 EDIT dec: field[sel] == min -> max (wrap), else -1.
REQ-026 EDIT set_btn: sel < NUM_FIELDS-1 -> sel+1, stay EDIT; sel == NUM_FIELDS-1 -> COMMIT.
REQ-027 EDIT cancel_btn: -> IDLE, no commit, field registers retained, sel <= 0.
REQ-028 Timeout counter cleared on entry to EDIT and on any button pulse; increments each EDIT cycle otherwise; reaching TIMEOUT -> IDLE, timed_out pulses 1 cycle, no commit.
REQ-029 COMMIT (1 cycle): commit = 1, commit_val = field registers; -> IDLE, sel <= 0.
REQ-030 Latency: set_btn in IDLE at cycle n -> editing high at n+1, edit_val valid at n+2; final set_btn at cycle m -> commit high at m+1.
REQ-031 Buttons arriving in LOAD or COMMIT are ignored.
REQ-032 cur_val changes after LOAD do not affect field registers.
REQ-033 edit_val = field[sel] every cycle, including IDLE.

Reset
REQ-034 rst_n low asynchronously forces: state IDLE, editing 0, sel 0, all field registers 0, edit_val 0, commit 0, commit_val 0, timed_out 0, timeout counter 0.
REQ-035 Reset asserted mid-edit discards all edits; no commit or timed_out strobe on release.
REQ-036 First state transition possible on first posedge clk after rst_n deasserts.

Verification
REQ-037 Defaults; min {0,0,0}, max {23,59,59}, cur_val {12,30,45}; set, inc x2, set, dec, set, set -> commit once, commit_val {14,29,45}.
REQ-038 Field 0 = 23, inc -> 0; field 1 = 0, dec -> 59; wrap checked on edit_val next cycle.
REQ-039 cur_val field 1 = 63 (above max 59) -> after LOAD field 1 = 0 (min).
REQ-040 TIMEOUT=10: set, then no buttons -> timed_out pulse 1 cycle, editing 0, commit never asserts.
REQ-041 EDIT cycle with cancel_btn and set_btn both high -> IDLE, no commit; inc_btn+dec_btn together -> edit_val unchanged.
REQ-042 rst_n low during EDIT with sel=2 -> immediately editing 0, sel 0, fields 0; no strobes after release.
